// File: rtl/ysyx_dmem_responder.sv
// LSU-side data memory responder: one load or store in flight, programmable
// response latency, word-organised SRAM model with byte enables.
module ysyx_dmem_responder #(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter logic [ADDR_W-1:0] BASE       = 32'h8000_0000,
  parameter int                DEPTH_LOG2 = 12,
  parameter int                RD_LAT     = 2,
  parameter int                WR_LAT     = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [ADDR_W-1:0] i_araddr,
  input  logic              i_arvalid,
  input  logic [7:0]        i_rstrb,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_rvalid,
  input  logic [ADDR_W-1:0] i_awaddr,
  input  logic              i_awvalid,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [7:0]        i_wstrb,
  input  logic              i_wvalid,
  output logic              o_wready,
  output logic              o_fault
);

  localparam int                DEPTH = 1 << DEPTH_LOG2;
  localparam logic [ADDR_W-1:0] SPAN  = ADDR_W'(4) << DEPTH_LOG2;

  typedef enum logic [1:0] {S_IDLE, S_RD_WAIT, S_WR_WAIT, S_ACK} state_t;

  state_t              r_state;
  logic [3:0]          r_cnt;
  logic                r_is_wr;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [7:0]          r_strb;
  logic                r_rvalid, r_wready, r_fault;
  logic [DATA_W-1:0]   r_rdata;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic                  w_st_req, w_idle, w_fire, w_fire_wr, w_fault;
  logic [ADDR_W-1:0]     w_addr, w_off;
  logic [7:0]            w_strb;
  logic [2:0]            w_size;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic [4:0]            w_shamt;
  logic [DATA_W-1:0]     w_rword, w_wd;
  logic [3:0]            w_be;

  assign w_st_req = i_awvalid & i_wvalid;
  assign w_idle   = (r_state == S_IDLE);

  // In IDLE the request being captured is checked straight from the inputs so
  // a latency of 1 can respond on the cycle after capture.
  assign w_addr = w_idle ? (w_st_req ? i_awaddr : i_araddr) : r_addr;
  assign w_strb = w_idle ? (w_st_req ? i_wstrb  : i_rstrb)  : r_strb;
  assign w_off  = w_addr - BASE;

  always_comb begin
    w_size = 3'd0;
    case (w_strb)
      8'h01:   w_size = 3'd1;
      8'h03:   w_size = 3'd2;
      8'h0f:   w_size = 3'd4;
      default: w_size = 3'd0;
    endcase
  end

  assign w_fault = (w_size == 3'd0) || (w_off >= SPAN) ||
                   (({1'b0, w_addr[1:0]} + w_size) > 3'd4);
  assign w_idx   = w_off[DEPTH_LOG2+1:2];
  assign w_shamt = {w_addr[1:0], 3'b000};
  assign w_rword = r_mem[w_idx] >> w_shamt;
  assign w_be    = 4'(r_strb[3:0] << r_addr[1:0]);
  assign w_wd    = r_wdata << w_shamt;

  assign w_fire    = w_idle ? (w_st_req ? (WR_LAT == 1) : (i_arvalid && (RD_LAT == 1)))
                            : ((r_state != S_ACK) && (r_cnt == 4'd1));
  assign w_fire_wr = w_idle ? w_st_req : r_is_wr;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_is_wr  <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_strb   <= 8'h0;
      r_rvalid <= 1'b0;
      r_wready <= 1'b0;
      r_fault  <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= 1'b0;
      r_wready <= 1'b0;
      r_fault  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_st_req) begin
            r_is_wr <= 1'b1;
            r_addr  <= i_awaddr;
            r_wdata <= i_wdata;
            r_strb  <= i_wstrb;
            r_cnt   <= 4'(WR_LAT - 1);
            r_state <= S_WR_WAIT;
          end else if (i_arvalid) begin
            r_is_wr <= 1'b0;
            r_addr  <= i_araddr;
            r_strb  <= i_rstrb;
            r_cnt   <= 4'(RD_LAT - 1);
            r_state <= S_RD_WAIT;
          end
        end
        S_RD_WAIT, S_WR_WAIT: begin
          if (r_cnt == 4'd0) r_state <= S_ACK;
          else               r_cnt   <= r_cnt - 4'd1;
        end
        // Only the lines of the serviced request must drop, so a load held
        // behind a winning store is still picked up afterwards.
        S_ACK: begin
          if (r_is_wr ? !(i_awvalid || i_wvalid) : !i_arvalid) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
      if (w_fire) begin
        r_fault <= w_fault;
        if (w_fire_wr) r_wready <= 1'b1;
        else begin
          r_rvalid <= 1'b1;
          r_rdata  <= w_fault ? '0 : w_rword;
        end
      end
    end
  end

  // Commit at the edge that ends the wready cycle; reset clears r_wready first.
  always_ff @(posedge i_clk) begin
    if (r_wready && !r_fault) begin
      for (int b = 0; b < 4; b++)
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wd[8*b +: 8];
    end
  end

  assign o_rdata  = r_rdata;
  assign o_rvalid = r_rvalid;
  assign o_wready = r_wready;
  assign o_fault  = r_fault;

endmodule

// File: tb/tb_ysyx_dmem_responder.sv
// Directed bench for ysyx_dmem_responder: default latencies on u_dut,
// RD_LAT=3 on u_dut3 for the mid-access reset case.
module tb_ysyx_dmem_responder;

  logic        clk, rst, b_rst;
  logic [31:0] araddr, awaddr, wdata, rdata;
  logic        arvalid, awvalid, wvalid, rvalid, wready, fault;
  logic [7:0]  rstrb, wstrb;
  logic [31:0] b_araddr, b_awaddr, b_wdata, b_rdata;
  logic        b_arvalid, b_awvalid, b_wvalid, b_rvalid, b_wready, b_fault;
  logic [7:0]  b_rstrb, b_wstrb;

  int n_tests = 0;
  int n_fail  = 0;

  ysyx_dmem_responder u_dut (
    .i_clk(clk), .i_rst(rst),
    .i_araddr(araddr), .i_arvalid(arvalid), .i_rstrb(rstrb),
    .o_rdata(rdata), .o_rvalid(rvalid),
    .i_awaddr(awaddr), .i_awvalid(awvalid), .i_wdata(wdata), .i_wstrb(wstrb),
    .i_wvalid(wvalid), .o_wready(wready), .o_fault(fault)
  );

  ysyx_dmem_responder #(.RD_LAT(3)) u_dut3 (
    .i_clk(clk), .i_rst(b_rst),
    .i_araddr(b_araddr), .i_arvalid(b_arvalid), .i_rstrb(b_rstrb),
    .o_rdata(b_rdata), .o_rvalid(b_rvalid),
    .i_awaddr(b_awaddr), .i_awvalid(b_awvalid), .i_wdata(b_wdata), .i_wstrb(b_wstrb),
    .i_wvalid(b_wvalid), .o_wready(b_wready), .o_fault(b_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Bus drivers: start and end at posedge+1, with the responder back in IDLE.
  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [7:0] s,
                          output int lat, output logic flt);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!wready && lat < 20);
    flt = fault;
    if (!wready) lat = -1;
    awvalid = 1'b0; wvalid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic do_load(input logic [31:0] a, input logic [7:0] s,
                         output int lat, output logic flt, output logic [31:0] d);
    araddr = a; rstrb = s; arvalid = 1'b1; lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!rvalid && lat < 20);
    flt = fault; d = rdata;
    if (!rvalid) lat = -1;
    arvalid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic b_store(input logic [31:0] a, input logic [31:0] d,
                         output int lat, output logic flt);
    b_awaddr = a; b_wdata = d; b_wstrb = 8'h0f; b_awvalid = 1'b1; b_wvalid = 1'b1; lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!b_wready && lat < 20);
    flt = b_fault;
    if (!b_wready) lat = -1;
    b_awvalid = 1'b0; b_wvalid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic b_load(input logic [31:0] a, output int lat, output logic flt,
                        output logic [31:0] d);
    b_araddr = a; b_rstrb = 8'h0f; b_arvalid = 1'b1; lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!b_rvalid && lat < 20);
    flt = b_fault; d = b_rdata;
    if (!b_rvalid) lat = -1;
    b_arvalid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset;
    n_tests++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %b want 0", rvalid); end
    n_tests++; if (wready !== 1'b0) begin n_fail++; $display("FAIL reset_wready: got %b want 0", wready); end
    n_tests++; if (fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault: got %b want 0", fault); end
    n_tests++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", rdata); end
  endtask

  task automatic test_word;
    int lat; logic flt; logic [31:0] d;
    do_store(32'h8000_0010, 32'hDEAD_BEEF, 8'h0f, lat, flt);
    n_tests++; if (lat !== 1) begin n_fail++; $display("FAIL word_st_lat: got %0d want 1", lat); end
    n_tests++; if (flt !== 1'b0) begin n_fail++; $display("FAIL word_st_fault: got %b want 0", flt); end
    do_load(32'h8000_0010, 8'h0f, lat, flt, d);
    n_tests++; if (lat !== 2) begin n_fail++; $display("FAIL word_ld_lat: got %0d want 2", lat); end
    n_tests++; if (flt !== 1'b0) begin n_fail++; $display("FAIL word_ld_fault: got %b want 0", flt); end
    n_tests++; if (d !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL word_ld_data: got %h want deadbeef", d); end
    n_tests++; if (rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rdata_hold: got %h want deadbeef", rdata); end
  endtask

  task automatic test_subword;
    int lat; logic flt; logic [31:0] d;
    do_store(32'h8000_0013, 32'h0000_005A, 8'h01, lat, flt);
    n_tests++; if (lat !== 1 || flt !== 1'b0) begin n_fail++; $display("FAIL byte_st: got lat %0d fault %b want 1/0", lat, flt); end
    do_load(32'h8000_0010, 8'h0f, lat, flt, d);
    n_tests++; if (d !== 32'h5AAD_BEEF || flt !== 1'b0) begin n_fail++; $display("FAIL byte_merge: got %h/%b want 5aadbeef/0", d, flt); end
    do_load(32'h8000_0012, 8'h03, lat, flt, d);
    n_tests++; if (d !== 32'h0000_5AAD || flt !== 1'b0) begin n_fail++; $display("FAIL half_ld: got %h/%b want 00005aad/0", d, flt); end
    do_load(32'h8000_0011, 8'h01, lat, flt, d);
    n_tests++; if (d !== 32'h005A_ADBE || flt !== 1'b0) begin n_fail++; $display("FAIL byte_ld: got %h/%b want 005aadbe/0", d, flt); end
    do_store(32'h8000_3FFC, 32'hA5A5_0F0F, 8'h0f, lat, flt);
    do_load(32'h8000_3FFC, 8'h0f, lat, flt, d);
    n_tests++; if (d !== 32'hA5A5_0F0F || flt !== 1'b0) begin n_fail++; $display("FAIL last_word: got %h/%b want a5a50f0f/0", d, flt); end
  endtask

  task automatic test_fault;
    int lat; logic flt; logic [31:0] d;
    do_load(32'h8000_0011, 8'h0f, lat, flt, d);
    n_tests++; if (lat !== 2 || flt !== 1'b1 || d !== 32'h0) begin n_fail++; $display("FAIL misaligned_ld: got lat %0d fault %b data %h want 2/1/0", lat, flt, d); end
    do_store(32'h8000_0000, 32'h1122_3344, 8'h0f, lat, flt);
    do_store(32'h8000_4000, 32'hFFFF_FFFF, 8'h0f, lat, flt);
    n_tests++; if (lat !== 1 || flt !== 1'b1) begin n_fail++; $display("FAIL range_st: got lat %0d fault %b want 1/1", lat, flt); end
    do_load(32'h8000_0000, 8'h0f, lat, flt, d);
    n_tests++; if (d !== 32'h1122_3344 || flt !== 1'b0) begin n_fail++; $display("FAIL range_st_nowrite: got %h/%b want 11223344/0", d, flt); end
    do_load(32'h8000_0010, 8'h07, lat, flt, d);
    n_tests++; if (flt !== 1'b1 || d !== 32'h0) begin n_fail++; $display("FAIL bad_strb: got fault %b data %h want 1/0", flt, d); end
    do_load(32'h8000_0013, 8'h03, lat, flt, d);
    n_tests++; if (flt !== 1'b1 || d !== 32'h0) begin n_fail++; $display("FAIL half_cross: got fault %b data %h want 1/0", flt, d); end
    do_load(32'h7FFF_FFFC, 8'h0f, lat, flt, d);
    n_tests++; if (flt !== 1'b1) begin n_fail++; $display("FAIL below_base: got fault %b want 1", flt); end
  endtask

  task automatic test_simultaneous;
    int cyc = 0, wlat = -1, rlat = -1, npulse = 0;
    logic [31:0] d = 32'h0;
    awaddr = 32'h8000_0020; wdata = 32'hCAFE_F00D; wstrb = 8'h0f;
    araddr = 32'h8000_0020; rstrb = 8'h0f;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    while (cyc < 20 && rlat < 0) begin
      @(posedge clk); #1; cyc++;
      if (wready) begin wlat = cyc; npulse++; awvalid = 1'b0; wvalid = 1'b0; end
      if (rvalid) begin rlat = cyc; d = rdata; end
    end
    arvalid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    n_tests++; if (wlat !== 1 || npulse !== 1) begin n_fail++; $display("FAIL simul_store: got lat %0d pulses %0d want 1/1", wlat, npulse); end
    n_tests++; if (rlat !== 5) begin n_fail++; $display("FAIL simul_load_lat: got %0d want 5", rlat); end
    n_tests++; if (d !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL simul_load_data: got %h want cafef00d", d); end
  endtask

  task automatic test_hold;
    int cyc = 0, rlat = -1, npulse = 0, lat;
    logic flt; logic [31:0] d;
    araddr = 32'h8000_0010; rstrb = 8'h0f; arvalid = 1'b1;
    while (cyc < 20 && rlat < 0) begin
      @(posedge clk); #1; cyc++;
      if (rvalid) rlat = cyc;
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (rvalid || wready) npulse++;
      if (i == 4) araddr = 32'h8000_0020;
    end
    n_tests++; if (rlat !== 2) begin n_fail++; $display("FAIL hold_first: got lat %0d want 2", rlat); end
    n_tests++; if (npulse !== 0) begin n_fail++; $display("FAIL hold_retrigger: got %0d extra pulses want 0", npulse); end
    arvalid = 1'b0;
    @(posedge clk); #1;
    do_load(32'h8000_0020, 8'h0f, lat, flt, d);
    n_tests++; if (lat !== 2 || d !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL hold_next: got lat %0d data %h want 2/cafef00d", lat, d); end
  endtask

  task automatic test_reset_mid;
    int lat, npulse = 0;
    logic flt; logic [31:0] d;
    b_store(32'h8000_0040, 32'h0BAD_F00D, lat, flt);
    b_load(32'h8000_0040, lat, flt, d);
    n_tests++; if (lat !== 3 || d !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL lat3_ld: got lat %0d data %h want 3/0badf00d", lat, d); end
    b_araddr = 32'h8000_0040; b_arvalid = 1'b1;
    @(posedge clk); #1;
    b_rst = 1'b1; #1;
    n_tests++; if ({b_rvalid, b_wready, b_fault} !== 3'b000 || b_rdata !== 32'h0) begin
      n_fail++; $display("FAIL mid_reset_outs: got %b%b%b data %h want 000/0", b_rvalid, b_wready, b_fault, b_rdata); end
    b_arvalid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (i == 1) b_rst = 1'b0;
      if (b_rvalid || b_wready || b_fault) npulse++;
    end
    n_tests++; if (npulse !== 0) begin n_fail++; $display("FAIL mid_reset_pulse: got %0d pulses want 0", npulse); end
    b_load(32'h8000_0040, lat, flt, d);
    n_tests++; if (lat !== 3 || flt !== 1'b0 || d !== 32'h0BAD_F00D) begin
      n_fail++; $display("FAIL post_reset_ld: got lat %0d fault %b data %h want 3/0/0badf00d", lat, flt, d); end
  endtask

  initial begin
    rst = 1'b1; b_rst = 1'b1;
    araddr = '0; arvalid = 1'b0; rstrb = 8'h0;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = 8'h0; wvalid = 1'b0;
    b_araddr = '0; b_arvalid = 1'b0; b_rstrb = 8'h0;
    b_awaddr = '0; b_awvalid = 1'b0; b_wdata = '0; b_wstrb = 8'h0; b_wvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset;
    rst = 1'b0; b_rst = 1'b0;
    @(posedge clk); #1;
    test_word;
    test_subword;
    test_fault;
    test_simultaneous;
    test_hold;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
